// File: rtl/imu_uart_packetizer_pkg.sv
// Shared definitions for the IMU UART packetizer: header default, FSM encoding, packet sizing.
package imu_pkt_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  function automatic int bpc(input int width);
    return (width + 7) / 8;
  endfunction

  // header + seq + data bytes + flags + chk
  function automatic int pkt_len(input int n_ch, input int width);
    return n_ch * bpc(width) + 4;
  endfunction

endpackage

// File: rtl/imu_uart_packetizer_if.sv
// Sample-in / serial-out bundle of the IMU UART packetizer.
interface imu_uart_packetizer_if #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 3
);
  logic                    sample_valid;
  logic [N_CH*WIDTH-1:0]   sample_data;
  logic [N_CH-1:0]         event_flags;
  logic                    tx;
  logic                    pkt_busy;
  logic                    pkt_done;
  logic [15:0]             drop_count;

  modport master (
    output sample_valid, sample_data, event_flags,
    input  tx, pkt_busy, pkt_done, drop_count
  );

  modport slave (
    input  sample_valid, sample_data, event_flags,
    output tx, pkt_busy, pkt_done, drop_count
  );
endinterface

// File: rtl/imu_uart_packetizer_uart_tx.sv
// 8N1 UART transmitter: tx_start accepted when idle, tx_busy high until the stop bit ends.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 1_843_200,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);
  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
      busy    <= 1'b0;
    end else if (!busy) begin
      if (tx_start) begin
        shreg   <= {1'b1, tx_data, 1'b0};
        busy    <= 1'b1;
        bit_cnt <= '0;
        clk_cnt <= '0;
      end
    end else if (clk_cnt == CW'(CPB - 1)) begin
      clk_cnt <= '0;
      shreg   <= {1'b1, shreg[9:1]};
      if (bit_cnt == 4'd9) busy <= 1'b0;
      else                 bit_cnt <= bit_cnt + 4'd1;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

  // Line is forced idle by reset without waiting for a clock.
  assign tx      = busy ? shreg[0] : 1'b1;
  assign tx_busy = busy;
endmodule

// File: rtl/imu_uart_packetizer.sv
// Snapshots N_CH samples + flags and streams them as a framed, checksummed packet over uart_tx.
module imu_uart_packetizer
  import imu_pkt_pkg::*;
#(
  parameter int         WIDTH       = 16,
  parameter int         N_CH        = 3,
  parameter int         CLK_FREQ_HZ = 1_843_200,
  parameter int         BAUD_RATE   = 115_200,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
  input logic                    clk,
  input logic                    rst,
  imu_uart_packetizer_if.slave   bus
);
  localparam int BPC   = bpc(WIDTH);
  localparam int L     = pkt_len(N_CH, WIDTH);
  localparam int NB    = N_CH * BPC;
  localparam int IDX_W = $clog2(L);

  state_t                state, state_nx;
  logic [IDX_W-1:0]      idx;
  logic [7:0]            chk, seq, cur_byte, flags_byte;
  logic [N_CH*WIDTH-1:0] snap_data, pend_data;
  logic [N_CH-1:0]       snap_flags, pend_flags;
  logic [NB*8-1:0]       padded;
  logic                  pending, pkt_busy, pkt_done;
  logic [15:0]           drop_count;
  logic                  tx_start, tx_busy, last_byte, byte_done, take_live;

  assign tx_start  = (state == SEND);
  assign last_byte = (idx == IDX_W'(L - 1));
  assign byte_done = (state == WAIT_DONE) && !tx_busy;
  assign take_live = (state == IDLE) && !pending && bus.sample_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (pending || bus.sample_valid) state_nx = LOAD;
      LOAD:      state_nx = SEND;
      SEND:      state_nx = WAIT_ACK;
      WAIT_ACK:  if (tx_busy) state_nx = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nx = !last_byte ? SEND : (pending ? LOAD : IDLE);
      default:   state_nx = IDLE;
    endcase
  end

  // Channels zero-padded to whole bytes so the byte mux is a plain slice.
  always_comb begin
    padded = '0;
    for (int k = 0; k < N_CH; k++) padded[k*BPC*8 +: WIDTH] = snap_data[k*WIDTH +: WIDTH];
    flags_byte = '0;
    flags_byte[N_CH-1:0] = snap_flags;
    cur_byte = 8'h00;
    if (idx == IDX_W'(0))          cur_byte = HEADER;
    else if (idx == IDX_W'(1))     cur_byte = seq;
    else if (idx == IDX_W'(L - 2)) cur_byte = flags_byte;
    else if (last_byte)            cur_byte = chk;
    else
      for (int b = 0; b < NB; b++)
        if (idx == IDX_W'(b + 2)) cur_byte = padded[b*8 +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      chk        <= '0;
      seq        <= '0;
      pkt_busy   <= 1'b0;
      pkt_done   <= 1'b0;
      pending    <= 1'b0;
      drop_count <= '0;
      snap_data  <= '0;
      snap_flags <= '0;
      pend_data  <= '0;
      pend_flags <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (state == LOAD) begin
        idx      <= '0;
        chk      <= '0;
        pkt_busy <= 1'b1;
      end
      if (tx_start && idx != IDX_W'(0) && !last_byte) chk <= chk ^ cur_byte;
      if (byte_done) begin
        if (last_byte) begin
          pkt_done <= 1'b1;
          seq      <= seq + 8'd1;
          pkt_busy <= (state_nx == LOAD);
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      // A strobe landing while the buffer is being consumed refills it without counting a drop.
      if (take_live) begin
        snap_data  <= bus.sample_data;
        snap_flags <= bus.event_flags;
      end else if (state == LOAD && pending) begin
        snap_data  <= pend_data;
        snap_flags <= pend_flags;
        pending    <= bus.sample_valid;
        if (bus.sample_valid) begin
          pend_data  <= bus.sample_data;
          pend_flags <= bus.event_flags;
        end
      end else if (bus.sample_valid) begin
        pend_data  <= bus.sample_data;
        pend_flags <= bus.event_flags;
        pending    <= 1'b1;
        if (pending && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  uart_tx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD_RATE   (BAUD_RATE)
  ) u_tx (
    .clk      (clk),
    .rst_n    (~rst),
    .tx_start (tx_start),
    .tx_data  (cur_byte),
    .tx_busy  (tx_busy),
    .tx       (bus.tx)
  );

  assign bus.pkt_busy   = pkt_busy;
  assign bus.pkt_done   = pkt_done;
  assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_imu_uart_packetizer.sv
// Directed bench: decodes the serial line and checks framing, latency, overrun, wrap and reset.
module tb_imu_uart_packetizer;
  localparam int CPB_M = 16;
  localparam int CPB_F = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imu_uart_packetizer_if #(.WIDTH(16), .N_CH(3)) bus   ();
  imu_uart_packetizer_if #(.WIDTH(16), .N_CH(3)) bus_f ();

  imu_uart_packetizer #(.WIDTH(16), .N_CH(3), .CLK_FREQ_HZ(1_843_200), .BAUD_RATE(115_200),
                        .HEADER(8'hAA)) dut (.clk(clk), .rst(rst), .bus(bus));
  imu_uart_packetizer #(.WIDTH(16), .N_CH(3), .CLK_FREQ_HZ(115_200), .BAUD_RATE(115_200),
                        .HEADER(8'hAA)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));

  int nvec = 0;
  int nerr = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_f[$];
  int starts = 0, wide = 0, busy_starts = 0, done_cnt = 0;
  logic prev_start = 1'b0;

  initial forever begin : mon_m
    logic [7:0] b;
    @(negedge clk);
    if (bus.tx === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (CPB_M) @(negedge clk);
        b[i] = bus.tx;
      end
      repeat (CPB_M) @(negedge clk);
      q_m.push_back(b);
    end
  end

  initial forever begin : mon_f
    logic [7:0] b;
    @(negedge clk);
    if (bus_f.tx === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (CPB_F) @(negedge clk);
        b[i] = bus_f.tx;
      end
      repeat (CPB_F) @(negedge clk);
      q_f.push_back(b);
    end
  end

  always @(posedge clk) begin
    prev_start <= dut.tx_start;
    if (dut.tx_start) begin
      starts <= starts + 1;
      if (prev_start)  wide <= wide + 1;
      if (dut.tx_busy) busy_starts <= busy_starts + 1;
    end
    if (bus.pkt_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] mk_pkt(input logic [7:0] s, input logic [47:0] d, input logic [2:0] f);
    logic [79:0] p;
    logic [7:0]  x;
    p = '0;
    p[7:0]  = 8'hAA;
    p[15:8] = s;
    p[63:16] = d;
    p[71:64] = {5'b0, f};
    x = 8'h00;
    for (int j = 1; j < 9; j++) x = x ^ p[j*8 +: 8];
    p[79:72] = x;
    return p;
  endfunction

  task automatic strobe(input bit fast, input logic [47:0] d, input logic [2:0] f);
    @(negedge clk);
    if (fast) begin bus_f.sample_data = d; bus_f.event_flags = f; bus_f.sample_valid = 1'b1; end
    else      begin bus.sample_data   = d; bus.event_flags   = f; bus.sample_valid   = 1'b1; end
    @(negedge clk);
    bus.sample_valid   = 1'b0;
    bus_f.sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit fast, input int budget, output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      got = fast ? bus_f.pkt_done : bus.pkt_done;
    end
    chk({tag, "_done_seen"}, {31'b0, got}, 32'd1);
  endtask

  task automatic get_byte(input bit fast, output logic [7:0] b);
    int n;
    n = 0;
    while ((fast ? q_f.size() : q_m.size()) == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (fast ? q_f.size() == 0 : q_m.size() == 0) b = 8'hxx;
    else if (fast) b = q_f.pop_front();
    else           b = q_m.pop_front();
  endtask

  task automatic check_pkt(input string tag, input bit fast, input logic [79:0] exp);
    logic [7:0] b;
    for (int j = 0; j < 10; j++) begin
      get_byte(fast, b);
      chk($sformatf("%s_b%0d", tag, j), {24'b0, b}, {24'b0, exp[j*8 +: 8]});
    end
  endtask

  initial begin
    int cyc;
    bus.sample_valid = 1'b0; bus.sample_data = '0; bus.event_flags = '0;
    bus_f.sample_valid = 1'b0; bus_f.sample_data = '0; bus_f.event_flags = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",       {31'b0, bus.tx},       32'd1);
    chk("rst_busy",     {31'b0, bus.pkt_busy}, 32'd0);
    chk("rst_done",     {31'b0, bus.pkt_done}, 32'd0);
    chk("rst_drop",     {16'b0, bus.drop_count}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // single packet, latency and handshake
    strobe(1'b0, {16'h0005, 16'hABCD, 16'h1234}, 3'b101);
    chk("t1_start_early", {31'b0, dut.tx_start}, 32'd0);
    @(negedge clk);
    chk("t1_start_lat2",  {31'b0, dut.tx_start}, 32'd1);
    chk("t1_busy_set",    {31'b0, bus.pkt_busy}, 32'd1);
    wait_done("t1", 1'b0, 3000, cyc);
    chk("t1_done_time",   {31'b0, (cyc >= 1600 && cyc <= 1650)}, 32'd1);
    chk("t1_busy_drop",   {31'b0, bus.pkt_busy}, 32'd0);
    check_pkt("t1", 1'b0, {8'h40, 8'h05, 8'h00, 8'h05, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h00, 8'hAA});
    repeat (50) @(negedge clk);
    chk("t1_done_once",   done_cnt, 32'd1);
    chk("t1_starts",      starts,   32'd10);

    // reset during byte 4
    strobe(1'b0, {16'h0000, 16'h0300, 16'h5555}, 3'b000);
    cyc = 0;
    while (q_m.size() < 4 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("t4_reach_b4", {31'b0, q_m.size() >= 4}, 32'd1);
    repeat (40) @(negedge clk);
    chk("t4_tx_before", {31'b0, bus.tx}, 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_tx_now",   {31'b0, bus.tx},         32'd1);
    chk("t4_busy",     {31'b0, bus.pkt_busy},   32'd0);
    chk("t4_done",     {31'b0, bus.pkt_done},   32'd0);
    chk("t4_drop",     {16'b0, bus.drop_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    q_m.delete();
    strobe(1'b0, {16'h0E0F, 16'h0C0D, 16'h0A0B}, 3'b100);
    wait_done("t4", 1'b0, 3000, cyc);
    check_pkt("t4", 1'b0, {8'h05, 8'h04, 8'h0E, 8'h0F, 8'h0C, 8'h0D, 8'h0A, 8'h0B, 8'h00, 8'hAA});

    // overrun: three strobes during packet 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    q_m.delete();
    strobe(1'b0, {16'h3333, 16'h2222, 16'h1111}, 3'b000);
    repeat (300) @(negedge clk);
    strobe(1'b0, {16'hBEEF, 16'hDEAD, 16'hC0DE}, 3'b111);
    chk("t2_drop0", {16'b0, bus.drop_count}, 32'd0);
    repeat (100) @(negedge clk);
    strobe(1'b0, {16'h7E7E, 16'h8001, 16'h00FF}, 3'b011);
    chk("t2_drop1", {16'b0, bus.drop_count}, 32'd1);
    wait_done("t2p0", 1'b0, 3000, cyc);
    chk("t2_no_gap", {31'b0, bus.pkt_busy}, 32'd1);
    check_pkt("t2p0", 1'b0, {8'h00, 8'h00, 8'h33, 8'h33, 8'h22, 8'h22, 8'h11, 8'h11, 8'h00, 8'hAA});
    wait_done("t2p1", 1'b0, 3000, cyc);
    check_pkt("t2p1", 1'b0, {8'h7C, 8'h03, 8'h7E, 8'h7E, 8'h80, 8'h01, 8'h00, 8'hFF, 8'h01, 8'hAA});
    repeat (20) @(negedge clk);
    chk("t2_idle",     {31'b0, bus.pkt_busy},   32'd0);
    chk("t2_drop_end", {16'b0, bus.drop_count}, 32'd1);

    // sequence wrap over 257 packets
    q_f.delete();
    for (int i = 0; i < 257; i++) begin
      logic [47:0] d;
      logic [2:0]  f;
      logic [31:0] iv;
      iv = 32'(i);
      d = {16'(iv * 3), 16'(iv ^ 32'h5A5A), 16'(iv * 257)};
      f = iv[2:0];
      strobe(1'b1, d, f);
      wait_done($sformatf("wrap%0d", i), 1'b1, 400, cyc);
      check_pkt($sformatf("wrap%0d", i), 1'b1, mk_pkt(iv[7:0], d, f));
    end

    chk("hs_wide",       wide,        32'd0);
    chk("hs_busy_start", busy_starts, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
